// File: rtl/branch_mp_pkg.sv
// Shared types and helpers for the multi-port branch unit.
// Lane records are sized for the widest supported configuration; narrower builds use the low bits.
package branch_mp_pkg;

    localparam int MAX_VLEN     = 64;
    localparam int MAX_TID_BITS = 8;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        JAL     = 2'd1,
        JALR    = 2'd2
    } bu_op_t;

    typedef struct packed {
        logic                    valid;
        logic [MAX_VLEN-1:0]     result;
        logic [MAX_TID_BITS-1:0] trans_id;
        logic                    taken;
        logic [MAX_VLEN-1:0]     target;
        logic                    exc;
        logic                    mispred;
        logic [MAX_VLEN-1:0]     pc;
    } bu_lane_out_t;

    // Distance of a transaction from the commit pointer, modulo 2^bits.
    function automatic logic [MAX_TID_BITS-1:0] age(
        input logic [MAX_TID_BITS-1:0] id,
        input logic [MAX_TID_BITS-1:0] ptr,
        input int unsigned             bits
    );
        logic [MAX_TID_BITS-1:0] mask;
        mask = (MAX_TID_BITS'(1) << bits) - MAX_TID_BITS'(1);
        return (id - ptr) & mask;
    endfunction

endpackage

// File: rtl/bu_lane.sv
// One branch lane: resolves direction/target, detects misprediction and misaligned targets,
// and registers the result for one cycle.
module bu_lane
    import branch_mp_pkg::*;
#(
    parameter int VLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter bit RVC           = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  bu_op_t                   op_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [VLEN-1:0]          pc_i,
    input  logic [VLEN-1:0]          imm_i,
    input  logic [VLEN-1:0]          operand_a_i,
    input  logic                     comp_res_i,
    input  logic                     is_compressed_i,
    input  logic                     pred_taken_i,
    input  logic [VLEN-1:0]          pred_addr_i,
    output bu_lane_out_t             lane
);

    logic [VLEN-1:0] inc;
    logic [VLEN-1:0] link;
    logic [VLEN-1:0] target;
    logic [VLEN-1:0] next_pc;
    logic [VLEN-1:0] pred_pc;
    logic            taken;
    logic            exc;
    logic            mispred;
    bu_lane_out_t    lane_d;

    // An excepting lane never reports a mispredict; the exception path redirects instead.
    always_comb begin
        inc     = is_compressed_i ? VLEN'(2) : VLEN'(4);
        link    = pc_i + inc;
        target  = ((op_i == JALR) ? operand_a_i : pc_i) + imm_i;
        if (op_i == JALR) begin
            target[0] = 1'b0;
        end
        taken   = (op_i != BR_COND) | comp_res_i;
        next_pc = taken ? target : link;
        exc     = taken & ~RVC & target[1];
        pred_pc = pred_taken_i ? pred_addr_i : link;
        mispred = ~exc & (next_pc != pred_pc);

        lane_d          = '0;
        lane_d.valid    = 1'b1;
        lane_d.result   = MAX_VLEN'(link);
        lane_d.trans_id = MAX_TID_BITS'(trans_id_i);
        lane_d.taken    = taken & ~exc;
        lane_d.target   = MAX_VLEN'(target);
        lane_d.exc      = exc;
        lane_d.mispred  = mispred;
        lane_d.pc       = MAX_VLEN'(pc_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane <= '0;
        end else if (flush_i || !valid_i) begin
            lane <= '0;
        end else begin
            lane <= lane_d;
        end
    end

endmodule

// File: rtl/branch_unit_mp.sv
// Multi-port branch unit: NR_PORTS resolving lanes, an oldest-mispredict select across lanes,
// and a pending register holding the oldest mispredict until the frontend flushes.
module branch_unit_mp
    import branch_mp_pkg::*;
#(
    parameter int NR_PORTS      = 2,
    parameter int VLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter bit RVC           = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [TRANS_ID_BITS-1:0]          commit_ptr_i,
    input  logic [NR_PORTS-1:0]               valid_i,
    input  logic [NR_PORTS*2-1:0]             op_i,
    input  logic [NR_PORTS*TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [NR_PORTS*VLEN-1:0]          pc_i,
    input  logic [NR_PORTS*VLEN-1:0]          imm_i,
    input  logic [NR_PORTS*VLEN-1:0]          operand_a_i,
    input  logic [NR_PORTS-1:0]               comp_res_i,
    input  logic [NR_PORTS-1:0]               is_compressed_i,
    input  logic [NR_PORTS-1:0]               pred_taken_i,
    input  logic [NR_PORTS*VLEN-1:0]          pred_addr_i,
    output logic [NR_PORTS-1:0]               result_valid_o,
    output logic [NR_PORTS*VLEN-1:0]          result_o,
    output logic [NR_PORTS*TRANS_ID_BITS-1:0] result_trans_id_o,
    output logic [NR_PORTS-1:0]               update_taken_o,
    output logic [NR_PORTS*VLEN-1:0]          update_target_o,
    output logic [NR_PORTS-1:0]               ex_valid_o,
    output logic [NR_PORTS*VLEN-1:0]          ex_tval_o,
    output logic                              mispredict_valid_o,
    output logic [VLEN-1:0]                   mispredict_pc_o,
    output logic [VLEN-1:0]                   mispredict_target_o,
    output logic [TRANS_ID_BITS-1:0]          mispredict_trans_id_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    bu_lane_out_t lanes [NR_PORTS];

    logic [0:0]              state;
    logic [VLEN-1:0]         pend_pc;
    logic [VLEN-1:0]         pend_target;
    logic [TRANS_ID_BITS-1:0] pend_tid;

    logic [MAX_TID_BITS-1:0] ptr_ext;
    logic [MAX_TID_BITS-1:0] lane_age;
    logic [MAX_TID_BITS-1:0] held_age;
    logic                    cand_found;
    logic [MAX_TID_BITS-1:0] cand_age;
    logic [VLEN-1:0]         cand_pc;
    logic [VLEN-1:0]         cand_target;
    logic [TRANS_ID_BITS-1:0] cand_tid;

    for (genvar i = 0; i < NR_PORTS; i++) begin : g_lane
        bu_lane #(
            .VLEN          (VLEN),
            .TRANS_ID_BITS (TRANS_ID_BITS),
            .RVC           (RVC)
        ) u_lane (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .flush_i         (flush_i),
            .valid_i         (valid_i[i]),
            .op_i            (bu_op_t'(op_i[i*2 +: 2])),
            .trans_id_i      (trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS]),
            .pc_i            (pc_i[i*VLEN +: VLEN]),
            .imm_i           (imm_i[i*VLEN +: VLEN]),
            .operand_a_i     (operand_a_i[i*VLEN +: VLEN]),
            .comp_res_i      (comp_res_i[i]),
            .is_compressed_i (is_compressed_i[i]),
            .pred_taken_i    (pred_taken_i[i]),
            .pred_addr_i     (pred_addr_i[i*VLEN +: VLEN]),
            .lane            (lanes[i])
        );
    end

    always_comb begin
        result_valid_o    = '0;
        result_o          = '0;
        result_trans_id_o = '0;
        update_taken_o    = '0;
        update_target_o   = '0;
        ex_valid_o        = '0;
        ex_tval_o         = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            result_valid_o[i]                                   = lanes[i].valid;
            result_o[i*VLEN +: VLEN]                            = lanes[i].result[VLEN-1:0];
            result_trans_id_o[i*TRANS_ID_BITS +: TRANS_ID_BITS] = lanes[i].trans_id[TRANS_ID_BITS-1:0];
            update_taken_o[i]                                   = lanes[i].taken;
            update_target_o[i*VLEN +: VLEN]                     = lanes[i].target[VLEN-1:0];
            ex_valid_o[i]                                       = lanes[i].exc;
            ex_tval_o[i*VLEN +: VLEN]                           = lanes[i].exc ? lanes[i].target[VLEN-1:0] : '0;
        end
    end

    // Strict less-than in ascending lane order gives equal ages to the lower lane.
    always_comb begin
        ptr_ext     = MAX_TID_BITS'(commit_ptr_i);
        lane_age    = '0;
        cand_found  = 1'b0;
        cand_age    = '0;
        cand_pc     = '0;
        cand_target = '0;
        cand_tid    = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            lane_age = age(lanes[i].trans_id, ptr_ext, TRANS_ID_BITS);
            if (lanes[i].valid && lanes[i].mispred && (!cand_found || lane_age < cand_age)) begin
                cand_found  = 1'b1;
                cand_age    = lane_age;
                cand_pc     = lanes[i].pc[VLEN-1:0];
                cand_target = lanes[i].taken ? lanes[i].target[VLEN-1:0] : lanes[i].result[VLEN-1:0];
                cand_tid    = lanes[i].trans_id[TRANS_ID_BITS-1:0];
            end
        end
        held_age = age(MAX_TID_BITS'(pend_tid), ptr_ext, TRANS_ID_BITS);
    end

    // Younger candidates arriving while HELD are dropped; the pending flush kills them anyway.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            pend_pc     <= '0;
            pend_target <= '0;
            pend_tid    <= '0;
        end else if (flush_i) begin
            state       <= ST_IDLE;
            pend_pc     <= '0;
            pend_target <= '0;
            pend_tid    <= '0;
        end else if (cand_found && (state == ST_IDLE || cand_age < held_age)) begin
            state       <= ST_HELD;
            pend_pc     <= cand_pc;
            pend_target <= cand_target;
            pend_tid    <= cand_tid;
        end
    end

    assign mispredict_valid_o    = (state == ST_HELD);
    assign mispredict_pc_o       = pend_pc;
    assign mispredict_target_o   = pend_target;
    assign mispredict_trans_id_o = pend_tid;

endmodule

// File: tb/tb_branch_unit_mp.sv
// Bench for branch_unit_mp: one RVC=0 and one RVC=1 instance share stimulus and are compared
// against a cycle-level reference model built from the resolution rules.
module tb_branch_unit_mp;

    localparam int NP = 2;
    localparam int VL = 64;
    localparam int TB = 3;

    localparam logic [1:0] OP_BR   = 2'd0;
    localparam logic [1:0] OP_JAL  = 2'd1;
    localparam logic [1:0] OP_JALR = 2'd2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [TB-1:0]     commit_ptr;
    logic [NP-1:0]     valid;
    logic [2*NP-1:0]   op;
    logic [NP*TB-1:0]  trans_id;
    logic [NP*VL-1:0]  pc, imm, opa, pred_addr;
    logic [NP-1:0]     comp_res, is_comp, pred_taken;

    logic [1:0][NP-1:0]    res_valid, upd_taken, ex_valid;
    logic [1:0][NP*VL-1:0] result, upd_target, ex_tval;
    logic [1:0][NP*TB-1:0] res_tid;
    logic [1:0]            mp_valid;
    logic [1:0][VL-1:0]    mp_pc, mp_target;
    logic [1:0][TB-1:0]    mp_tid;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        branch_unit_mp #(
            .NR_PORTS      (NP),
            .VLEN          (VL),
            .TRANS_ID_BITS (TB),
            .RVC           (d == 1)
        ) dut (
            .clk_i                 (clk),
            .rst_ni                (rst_n),
            .flush_i               (flush),
            .commit_ptr_i          (commit_ptr),
            .valid_i               (valid),
            .op_i                  (op),
            .trans_id_i            (trans_id),
            .pc_i                  (pc),
            .imm_i                 (imm),
            .operand_a_i           (opa),
            .comp_res_i            (comp_res),
            .is_compressed_i       (is_comp),
            .pred_taken_i          (pred_taken),
            .pred_addr_i           (pred_addr),
            .result_valid_o        (res_valid[d]),
            .result_o              (result[d]),
            .result_trans_id_o     (res_tid[d]),
            .update_taken_o        (upd_taken[d]),
            .update_target_o       (upd_target[d]),
            .ex_valid_o            (ex_valid[d]),
            .ex_tval_o             (ex_tval[d]),
            .mispredict_valid_o    (mp_valid[d]),
            .mispredict_pc_o       (mp_pc[d]),
            .mispredict_target_o   (mp_target[d]),
            .mispredict_trans_id_o (mp_tid[d])
        );
    end

    typedef struct {
        bit          v;
        logic [63:0] pc, res, tgt, nxt;
        logic [2:0]  tid;
        bit          taken, exc, mis;
    } exp_lane_t;

    exp_lane_t   exp_lane [2][NP];
    bit          exp_pv   [2];
    logic [63:0] exp_ppc  [2];
    logic [63:0] exp_ptgt [2];
    logic [2:0]  exp_ptid [2];

    int total = 0;
    int bad   = 0;

    function automatic exp_lane_t model_lane(input int rvc, input int l);
        exp_lane_t   e;
        logic [63:0] p, inc, base, pred;
        logic [1:0]  o;
        p     = pc[l*VL +: VL];
        o     = op[l*2 +: 2];
        inc   = is_comp[l] ? 64'd2 : 64'd4;
        base  = (o == OP_JALR) ? opa[l*VL +: VL] : p;
        e.tgt = base + imm[l*VL +: VL];
        if (o == OP_JALR) e.tgt = e.tgt & ~64'd1;
        e.v     = 1'b1;
        e.pc    = p;
        e.res   = p + inc;
        e.tid   = trans_id[l*TB +: TB];
        e.taken = (o != OP_BR) || comp_res[l];
        e.nxt   = e.taken ? e.tgt : p + inc;
        e.exc   = e.taken && (rvc == 0) && e.tgt[1];
        pred    = pred_taken[l] ? pred_addr[l*VL +: VL] : p + inc;
        e.mis   = !e.exc && (e.nxt != pred);
        return e;
    endfunction

    function automatic int age_of(input logic [2:0] id, input logic [2:0] ptr);
        return (int'(id) + 8 - int'(ptr)) % 8;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic compareAll();
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < NP; l++) begin
                checkOutput($sformatf("rvc%0d.l%0d.valid", d, l), 64'(res_valid[d][l]), 64'(exp_lane[d][l].v));
                checkOutput($sformatf("rvc%0d.l%0d.ex_valid", d, l), 64'(ex_valid[d][l]),
                            64'(exp_lane[d][l].v && exp_lane[d][l].exc));
                if (exp_lane[d][l].v) begin
                    checkOutput($sformatf("rvc%0d.l%0d.result", d, l), result[d][l*VL +: VL], exp_lane[d][l].res);
                    checkOutput($sformatf("rvc%0d.l%0d.tid", d, l), 64'(res_tid[d][l*TB +: TB]), 64'(exp_lane[d][l].tid));
                    checkOutput($sformatf("rvc%0d.l%0d.upd_taken", d, l), 64'(upd_taken[d][l]),
                                64'(exp_lane[d][l].taken && !exp_lane[d][l].exc));
                    checkOutput($sformatf("rvc%0d.l%0d.upd_target", d, l), upd_target[d][l*VL +: VL], exp_lane[d][l].tgt);
                    if (exp_lane[d][l].exc)
                        checkOutput($sformatf("rvc%0d.l%0d.tval", d, l), ex_tval[d][l*VL +: VL], exp_lane[d][l].tgt);
                end
            end
            checkOutput($sformatf("rvc%0d.mp_valid", d), 64'(mp_valid[d]), 64'(exp_pv[d]));
            if (exp_pv[d]) begin
                checkOutput($sformatf("rvc%0d.mp_pc", d), mp_pc[d], exp_ppc[d]);
                checkOutput($sformatf("rvc%0d.mp_target", d), mp_target[d], exp_ptgt[d]);
                checkOutput($sformatf("rvc%0d.mp_tid", d), 64'(mp_tid[d]), 64'(exp_ptid[d]));
            end
        end
    endtask

    // Advance one clock: predict the next state from current inputs, then compare.
    task automatic applyStimulus();
        exp_lane_t   nl [2][NP];
        bit          npv [2];
        logic [63:0] nppc [2], nptgt [2];
        logic [2:0]  nptid [2];
        int          best, bkey, key;
        for (int d = 0; d < 2; d++) begin
            npv[d] = exp_pv[d]; nppc[d] = exp_ppc[d]; nptgt[d] = exp_ptgt[d]; nptid[d] = exp_ptid[d];
            for (int l = 0; l < NP; l++) begin
                nl[d][l]   = model_lane(d, l);
                nl[d][l].v = valid[l] && !flush;
            end
            if (flush) begin
                npv[d] = 1'b0;
            end else begin
                best = -1; bkey = 0;
                for (int l = 0; l < NP; l++) begin
                    if (exp_lane[d][l].v && exp_lane[d][l].mis) begin
                        key = age_of(exp_lane[d][l].tid, commit_ptr) * NP + l;
                        if (best < 0 || key < bkey) begin best = l; bkey = key; end
                    end
                end
                if (best >= 0 && (!exp_pv[d] ||
                    age_of(exp_lane[d][best].tid, commit_ptr) < age_of(exp_ptid[d], commit_ptr))) begin
                    npv[d]   = 1'b1;
                    nppc[d]  = exp_lane[d][best].pc;
                    nptgt[d] = exp_lane[d][best].nxt;
                    nptid[d] = exp_lane[d][best].tid;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < NP; l++) exp_lane[d][l] = nl[d][l];
            exp_pv[d] = npv[d]; exp_ppc[d] = nppc[d]; exp_ptgt[d] = nptgt[d]; exp_ptid[d] = nptid[d];
        end
        compareAll();
    endtask

    task automatic clearInputs();
        flush = 1'b0; valid = '0; op = '0; trans_id = '0; pc = '0; imm = '0; opa = '0;
        comp_res = '0; is_comp = '0; pred_taken = '0; pred_addr = '0;
    endtask

    task automatic zeroModel();
        for (int d = 0; d < 2; d++) begin
            exp_pv[d] = 1'b0; exp_ppc[d] = '0; exp_ptgt[d] = '0; exp_ptid[d] = '0;
            for (int l = 0; l < NP; l++) begin
                exp_lane[d][l].v = 1'b0; exp_lane[d][l].exc = 1'b0; exp_lane[d][l].mis = 1'b0;
            end
        end
    endtask

    task automatic setLane(input int l, input logic [1:0] o, input logic [2:0] id,
                           input logic [63:0] p, input logic [63:0] im, input logic [63:0] a,
                           input bit cr, input bit cm, input bit pt, input logic [63:0] pa);
        valid[l] = 1'b1; op[l*2 +: 2] = o; trans_id[l*TB +: TB] = id;
        pc[l*VL +: VL] = p; imm[l*VL +: VL] = im; opa[l*VL +: VL] = a;
        comp_res[l] = cr; is_comp[l] = cm; pred_taken[l] = pt; pred_addr[l*VL +: VL] = pa;
    endtask

    task automatic randomLanes();
        exp_lane_t e;
        flush      = ($urandom_range(0, 9) == 0);
        commit_ptr = TB'($urandom_range(0, 7));
        for (int l = 0; l < NP; l++) begin
            setLane(l, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 'hFFFF)) & ~64'd1,
                    $urandom_range(0, 1) ? 64'($urandom_range(0, 255)) : -64'($urandom_range(0, 255)),
                    {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 64'($urandom_range(0, 'hFFFF)));
            valid[l] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                e = model_lane(1, l);
                pred_taken[l] = e.taken;
                pred_addr[l*VL +: VL] = e.nxt;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        commit_ptr = '0;
        clearInputs();
        zeroModel();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        compareAll();
        checkOutput("reset.mp_valid", 64'(mp_valid), 64'd0);

        // Taken branch predicted not-taken
        setLane(0, OP_BR, 3'd0, 64'h1000, 64'h40, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus();
        checkOutput("tp1.upd_target", upd_target[1][VL-1:0], 64'h1040);
        checkOutput("tp1.result", result[1][VL-1:0], 64'h1004);
        checkOutput("tp1.mp_early", 64'(mp_valid[1]), 64'd0);
        clearInputs();
        applyStimulus();
        checkOutput("tp1.mp_valid", 64'(mp_valid[1]), 64'd1);
        checkOutput("tp1.mp_target", mp_target[1], 64'h1040);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        checkOutput("tp1.flushed", 64'(mp_valid[1]), 64'd0);

        // Correctly predicted compressed JALR
        setLane(0, OP_JALR, 3'd1, 64'h1000, 64'h10, 64'h2001, 1'b0, 1'b1, 1'b1, 64'h2010);
        applyStimulus();
        checkOutput("tp2.upd_target", upd_target[1][VL-1:0], 64'h2010);
        checkOutput("tp2.result", result[1][VL-1:0], 64'h1002);
        clearInputs();
        applyStimulus();
        checkOutput("tp2.no_mp", 64'(mp_valid[1]), 64'd0);

        // Misaligned JAL target without compressed support
        setLane(0, OP_JAL, 3'd2, 64'h100, 64'h6, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
        applyStimulus();
        checkOutput("tp3.ex_valid", 64'(ex_valid[0][0]), 64'd1);
        checkOutput("tp3.tval", ex_tval[0][VL-1:0], 64'h106);
        clearInputs();
        applyStimulus();
        checkOutput("tp3.no_mp", 64'(mp_valid[0]), 64'd0);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;

        // Two mispredicts with wrapped ids
        commit_ptr = 3'd6;
        setLane(0, OP_BR, 3'd1, 64'h3000, 64'h20, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
        setLane(1, OP_BR, 3'd7, 64'h4000, 64'h20, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("tp4.mp_tid", 64'(mp_tid[1]), 64'd7);
        checkOutput("tp4.mp_pc", mp_pc[1], 64'h4000);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;

        // Held entry replaced by an older one, not by a younger one
        commit_ptr = 3'd0;
        setLane(0, OP_BR, 3'd3, 64'h5000, 64'h40, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("tp5.held_tid", 64'(mp_tid[1]), 64'd3);
        setLane(0, OP_BR, 3'd2, 64'h6000, 64'h80, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("tp5.replace_tid", 64'(mp_tid[1]), 64'd2);
        checkOutput("tp5.replace_pc", mp_pc[1], 64'h6000);
        checkOutput("tp5.replace_target", mp_target[1], 64'h6080);
        setLane(0, OP_BR, 3'd5, 64'h7000, 64'h40, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("tp5.keep_tid", 64'(mp_tid[1]), 64'd2);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        checkOutput("tp5.flushed", 64'(mp_valid[1]), 64'd0);

        // Asynchronous reset while HELD with valid lanes
        setLane(0, OP_BR, 3'd4, 64'h8000, 64'h40, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
        setLane(1, OP_JAL, 3'd5, 64'h8100, 64'h40, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
        applyStimulus();
        applyStimulus();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst.rvc%0d.res_valid", d), 64'(res_valid[d]), 64'd0);
            checkOutput($sformatf("rst.rvc%0d.mp_valid", d), 64'(mp_valid[d]), 64'd0);
            checkOutput($sformatf("rst.rvc%0d.result", d), result[d][VL-1:0], 64'd0);
            checkOutput($sformatf("rst.rvc%0d.upd_target", d), upd_target[d][VL-1:0], 64'd0);
        end
        clearInputs();
        zeroModel();
        @(posedge clk);
        #1 rst_n = 1'b1;
        setLane(0, OP_JAL, 3'd1, 64'h9000, 64'h10, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("rst.after_mp_target", mp_target[1], 64'h9010);
        flush = 1'b1;
        applyStimulus();

        for (int n = 0; n < 400; n++) begin
            randomLanes();
            applyStimulus();
        end
        clearInputs();
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_unit_mp.md
Name: branch_unit_mp

Overview:
Multi-port, parametrised successor to the single branch unit. It resolves up to NR_PORTS branch/jump instructions per cycle, each in its own lane, and registers every lane's result. Across lanes it selects the single oldest mispredict, measured relative to the scoreboard commit pointer, and holds it until the frontend flushes. It sits between issue (the FU data path) and the frontend/scoreboard, replacing the single-lane unit in dual-issue configurations.

Parameters:
NR_PORTS, 2, number of independent branch lanes (1..4)
VLEN, 64, virtual address width
TRANS_ID_BITS, 3, scoreboard transaction-id width; age arithmetic is modulo 2^TRANS_ID_BITS
RVC, 1, compressed ISA enabled; when 0, a target with bit[1] set is misaligned

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; also acknowledges the pending mispredict
commit_ptr_i  in  TRANS_ID_BITS  trans id of the oldest uncommitted instruction
valid_i  in  NR_PORTS  lane instruction valid
op_i  in  NR_PORTS*2  per-lane bu_op_t: BR_COND=0, JAL=1, JALR=2
trans_id_i  in  NR_PORTS*TRANS_ID_BITS  per-lane scoreboard id
pc_i  in  NR_PORTS*VLEN  instruction PC
imm_i  in  NR_PORTS*VLEN  sign-extended immediate
operand_a_i  in  NR_PORTS*VLEN  rs1 value, used for JALR
comp_res_i  in  NR_PORTS  condition result from the ALU, used for BR_COND
is_compressed_i  in  NR_PORTS  instruction is 16-bit
pred_taken_i  in  NR_PORTS  frontend predicted taken
pred_addr_i  in  NR_PORTS*VLEN  frontend predicted target
result_valid_o  out  NR_PORTS  lane result valid, registered
result_o  out  NR_PORTS*VLEN  link address, pc+2 or pc+4
result_trans_id_o  out  NR_PORTS*TRANS_ID_BITS  lane id
update_taken_o  out  NR_PORTS  resolved direction, for predictor training
update_target_o  out  NR_PORTS*VLEN  resolved target
ex_valid_o  out  NR_PORTS  misaligned-target exception
ex_tval_o  out  NR_PORTS*VLEN  faulting target
mispredict_valid_o  out  1  pending mispredict, held until flush_i
mispredict_pc_o  out  VLEN  PC of the mispredicting instruction
mispredict_target_o  out  VLEN  correct next PC
mispredict_trans_id_o  out  TRANS_ID_BITS  id of the mispredicting instruction

Behaviour:
- Reset: every output register and the pending register clear to 0. Reset is asynchronous and may occur mid-operation; all in-flight state is discarded.
- Lane compute (combinational):
  - inc = is_compressed ? 2 : 4.
  - target = (op==JALR ? operand_a : pc) + imm, computed modulo 2^VLEN. For JALR, bit0 is forced to 0.
  - taken = (op != BR_COND) | comp_res.
  - next_pc = taken ? target : pc + inc.
  - exc = taken & !RVC & target[1].
  - mispred = !exc & (next_pc != (pred_taken ? pred_addr : pc + inc)).
- Latency: all lane outputs are registered and appear exactly 1 cycle after valid_i. result_valid_o is a 1-cycle pulse per accepted instruction. ex_valid_o is asserted only together with result_valid_o.
- age(id) = (id - commit_ptr_i) mod 2^TRANS_ID_BITS, evaluated using the current-cycle commit_ptr_i.
- Mispredict select: among registered lanes with mispred set, choose the minimum age; equal age goes to the lower lane index.
- Pending register states:
  - IDLE: a candidate loads the register and moves to HELD; mispredict_valid_o rises the cycle after result_valid_o.
  - HELD: a new candidate replaces the held entry only if its age is strictly smaller than the held entry's age. Younger candidates are dropped, since the flush kills them.
- flush_i: clears all lane valids and the pending register next edge; state returns to IDLE. Lane inputs presented in the same cycle as flush_i are discarded. flush_i has priority over a simultaneous new candidate.
- Trans-id wrap-around: ordering uses age only, never the raw id. Example with TRANS_ID_BITS=3 and commit_ptr=6: id 7 (age 1) is older than id 1 (age 3).
- Predictor update outputs are produced for every valid lane, mispredicting or not. Exception lanes report update_taken_o=0.

Decomposition:
- Package branch_mp_pkg holds bu_op_t, the struct bu_lane_out_t {valid, result, trans_id, taken, target, exc, mispred, pc}, and the function age(id, ptr).
- Sub-module bu_lane is instantiated NR_PORTS times. It contains one lane's compute logic plus its output register, and has its own clk_i/rst_ni/flush_i.
- The top level holds the oldest-select tree and the pending register.

Test Plan:
- Lane0 BR_COND, pc=0x1000, imm=0x40, comp_res=1, pred_taken=0 -> next cycle: update_target=0x1040, result=0x1004. Cycle after that: mispredict_valid=1, target=0x1040.
- JALR, operand_a=0x2001, imm=0x10, pred_taken=1, pred_addr=0x2010 -> target=0x2010 (bit0 cleared), no mispredict. result=0x1002 when is_compressed=1 and pc=0x1000.
- RVC=0, JAL, pc=0x100, imm=0x6 -> ex_valid=1, tval=0x106, mispredict_valid stays 0.
- Two lanes mispredict in the same cycle with commit_ptr=6, ids 1 (lane0) and 7 (lane1) -> mispredict_trans_id=7.
- HELD with id 3 (commit_ptr=0). A new mispredict id 2 arrives -> replaces, pc/target updated. A later id 5 arrives -> ignored. flush_i -> mispredict_valid=0 next cycle.
- Assert rst_ni low while HELD and lanes are valid -> all outputs 0 immediately (asynchronous reset). After release, the first instruction resolves normally.
